// File: rtl/ir_cmd_pkg.sv
// Shared definitions for the IR command scheduler: byte codes, encoder
// command words, FSM state encoding and the decode helpers.
package ir_cmd_pkg;

  localparam logic [7:0] BYTE_UP    = 8'h38;
  localparam logic [7:0] BYTE_DOWN  = 8'h32;
  localparam logic [7:0] BYTE_RIGHT = 8'h36;
  localparam logic [7:0] BYTE_LEFT  = 8'h34;

  localparam logic [31:0] CMD_UP    = 32'h9F60_0707;
  localparam logic [31:0] CMD_DOWN  = 32'h9E61_0707;
  localparam logic [31:0] CMD_RIGHT = 32'h9D62_0707;
  localparam logic [31:0] CMD_LEFT  = 32'h9A65_0707;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  typedef struct packed {
    logic       known;
    logic [1:0] idx;
  } byte_dec_t;

  // Map a received UART byte onto a command index; unknown bytes flagged.
  function automatic byte_dec_t decode_byte(input logic [7:0] b);
    byte_dec_t d;
    d.known = 1'b1;
    d.idx   = 2'd0;
    case (b)
      BYTE_UP:    d.idx = 2'd0;
      BYTE_DOWN:  d.idx = 2'd1;
      BYTE_RIGHT: d.idx = 2'd2;
      BYTE_LEFT:  d.idx = 2'd3;
      default:    d.known = 1'b0;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] idx_to_word(input logic [1:0] idx);
    logic [31:0] w;
    case (idx)
      2'd0:    w = CMD_UP;
      2'd1:    w = CMD_DOWN;
      2'd2:    w = CMD_RIGHT;
      default: w = CMD_LEFT;
    endcase
    return w;
  endfunction

  function automatic logic [3:0] idx_to_led(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Small synchronous FIFO with full/empty flags. A pop in the same cycle as a
// push to a full FIFO frees the slot first, so both take effect.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic             empty_next
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    pop_ok   = pop && (count_q != '0);
    push_ok  = push && ((count_q != CNT_W'(DEPTH)) || pop_ok);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  // Storage array carries data only, so it is not reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Pointers and occupancy, cleared by the active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign pop_data   = mem_q[rd_ptr_q];
  assign full       = (count_q == CNT_W'(DEPTH));
  assign empty      = (count_q == '0);
  assign empty_next = (count_d == '0);

endmodule

// File: rtl/ir_cmd_scheduler.sv
// Queues decoded remote-control bytes and issues them to the IR encoder one
// frame at a time, enforcing an idle gap after every accepted frame.
module ir_cmd_scheduler
  import ir_cmd_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int GAP_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_strobe,
  input  logic        ir_ready,
  output logic [31:0] ir_cmd,
  output logic        ir_valid,
  output logic [3:0]  led,
  output logic        busy,
  output logic        overflow,
  output logic [7:0]  drop_cnt
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_e           state_q, state_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [31:0]      ir_cmd_q, ir_cmd_d;
  logic             ir_valid_q, ir_valid_d;
  logic [1:0]       cur_idx_q, cur_idx_d;
  logic [3:0]       led_q, led_d;
  logic             busy_q, busy_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;

  byte_dec_t        rx_dec;
  logic             fifo_push, fifo_pop;
  logic [1:0]       fifo_head;
  logic             fifo_full, fifo_empty, fifo_empty_next;
  logic             drop_unknown, drop_full;

  cmd_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(2)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (fifo_push),
    .push_data  (rx_dec.idx),
    .pop        (fifo_pop),
    .pop_data   (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .empty_next (fifo_empty_next)
  );

  // Issue FSM: pop in IDLE, hold the frame until the handshake, then wait out the gap.
  always_comb begin
    state_d    = state_q;
    gap_cnt_d  = gap_cnt_q;
    ir_cmd_d   = ir_cmd_q;
    ir_valid_d = ir_valid_q;
    cur_idx_d  = cur_idx_q;
    led_d      = led_q;
    fifo_pop   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          cur_idx_d  = fifo_head;
          ir_cmd_d   = idx_to_word(fifo_head);
          ir_valid_d = 1'b1;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (ir_valid_q && ir_ready) begin
          ir_valid_d = 1'b0;
          led_d      = idx_to_led(cur_idx_q);
          gap_cnt_d  = GAP_W'(GAP_CYCLES - 1);
          state_d    = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Byte decode, push request, drop statistics and the registered busy flag.
  always_comb begin
    rx_dec       = decode_byte(rx_data);
    fifo_push    = rx_strobe && rx_dec.known;
    drop_unknown = rx_strobe && !rx_dec.known;
    drop_full    = fifo_push && fifo_full && !fifo_pop;
    overflow_d   = overflow_q || drop_full;
    drop_cnt_d   = drop_cnt_q;
    if ((drop_unknown || drop_full) && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
    busy_d = (state_d != ST_IDLE) || !fifo_empty_next;
  end

  // Scheduler registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      gap_cnt_q  <= '0;
      ir_cmd_q   <= '0;
      ir_valid_q <= 1'b0;
      cur_idx_q  <= '0;
      led_q      <= '0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gap_cnt_q  <= gap_cnt_d;
      ir_cmd_q   <= ir_cmd_d;
      ir_valid_q <= ir_valid_d;
      cur_idx_q  <= cur_idx_d;
      led_q      <= led_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign ir_cmd   = ir_cmd_q;
  assign ir_valid = ir_valid_q;
  assign led      = led_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule
